// File: rtl/if_id_reg_pkg.sv
// Shared fetch/decode definitions: exception codes, instruction-memory
// address window, exception entry vector and the IF/ID slot record.
package if_id_reg_pkg;

    localparam logic [31:0] IM_BASE   = 32'h0000_3000;
    localparam logic [31:0] IM_END    = 32'h0000_6ffc;
    localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // What the register does on the coming edge, in priority order.
    typedef enum logic [1:0] {
        ACT_LOAD = 2'd0,
        ACT_HOLD = 2'd1,
        ACT_ERET = 2'd2,
        ACT_EXC  = 2'd3
    } slot_action_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exccode;
        logic        bd;
        logic        valid;
    } d_slot_t;

    // An empty decode slot that still carries a PC for exception bookkeeping.
    function automatic d_slot_t bubble(input logic [31:0] pc);
        d_slot_t s;
        s.pc      = pc;
        s.instr   = 32'h0;
        s.exccode = EXC_NONE;
        s.bd      = 1'b0;
        s.valid   = 1'b0;
        return s;
    endfunction

endpackage

// File: rtl/if_id_reg_if.sv
// Fetch-to-decode bundle: F-side inputs, pipeline controls, D-side outputs
// and the fetch performance counters.
interface if_id_reg_if;

    logic [31:0] F_PC;
    logic [31:0] F_instr;
    logic        F_bd;
    logic        hold;
    logic        exc;
    logic        eret;
    logic [31:0] EPC;

    logic [31:0] D_PC;
    logic [31:0] D_instr;
    logic [4:0]  D_exccode;
    logic        D_bd;
    logic        D_valid;
    logic [31:0] perf_fetched;
    logic [31:0] perf_stalls;

    modport master (
        output F_PC, F_instr, F_bd, hold, exc, eret, EPC,
        input  D_PC, D_instr, D_exccode, D_bd, D_valid, perf_fetched, perf_stalls
    );

    modport slave (
        input  F_PC, F_instr, F_bd, hold, exc, eret, EPC,
        output D_PC, D_instr, D_exccode, D_bd, D_valid, perf_fetched, perf_stalls
    );

endinterface

// File: rtl/if_id_reg_fetch_exc_check.sv
// Combinational fetch address check: flags AdEL for misaligned PCs or PCs
// outside the instruction-memory window (unsigned compare).
module fetch_exc_check
    import if_id_reg_pkg::*;
(
    input  logic [31:0] F_PC,
    output logic        adel
);

    logic misaligned;
    logic below_base;
    logic above_end;

    assign misaligned = (F_PC[1:0] != 2'b00);
    assign below_base = (F_PC < IM_BASE);
    assign above_end  = (F_PC > IM_END);
    assign adel       = misaligned | below_base | above_end;

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with AdEL tagging, stall hold and exc/eret flush.
// Optional fetch/stall counters are built when FETCH_PERF_CNT_EN is defined.
module if_id_reg
    import if_id_reg_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    if_id_reg_if.slave    bus
);

    logic         adel;
    slot_action_t action;
    d_slot_t      slot_reg;
    d_slot_t      slot_next;

    fetch_exc_check u_fetch_exc_check (
        .F_PC (bus.F_PC),
        .adel (adel)
    );

    // Flushes beat hold, so a stalled slot can still be cleared.
    always_comb begin
        action = ACT_LOAD;
        if (bus.exc) begin
            action = ACT_EXC;
        end else if (bus.eret) begin
            action = ACT_ERET;
        end else if (bus.hold) begin
            action = ACT_HOLD;
        end
    end

    always_comb begin
        slot_next = slot_reg;
        case (action)
            ACT_EXC:  slot_next = bubble(EXC_ENTRY);
            ACT_ERET: slot_next = bubble(bus.EPC);
            ACT_HOLD: slot_next = slot_reg;
            default: begin
                slot_next.pc    = bus.F_PC;
                slot_next.bd    = bus.F_bd;
                slot_next.valid = 1'b1;
                if (adel) begin
                    slot_next.instr   = 32'h0;
                    slot_next.exccode = EXC_ADEL;
                end else begin
                    slot_next.instr   = bus.F_instr;
                    slot_next.exccode = EXC_NONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_reg <= bubble(IM_BASE);
        end else begin
            slot_reg <= slot_next;
        end
    end

    assign bus.D_PC      = slot_reg.pc;
    assign bus.D_instr   = slot_reg.instr;
    assign bus.D_exccode = slot_reg.exccode;
    assign bus.D_bd      = slot_reg.bd;
    assign bus.D_valid   = slot_reg.valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_reg;
    logic [31:0] stalls_reg;

    // Only cleanly fetched instructions count; AdEL loads do not.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetched_reg <= 32'h0;
            stalls_reg  <= 32'h0;
        end else begin
            if (action == ACT_LOAD && !adel) begin
                fetched_reg <= fetched_reg + 32'd1;
            end
            if (action == ACT_HOLD) begin
                stalls_reg <= stalls_reg + 32'd1;
            end
        end
    end

    assign bus.perf_fetched = fetched_reg;
    assign bus.perf_stalls  = stalls_reg;
`else
    assign bus.perf_fetched = 32'h0;
    assign bus.perf_stalls  = 32'h0;
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// Directed, table-driven bench for if_id_reg plus async-reset sequences.
module tb_if_id_reg;

    logic clk;
    logic reset;

    if_id_reg_if bus ();

    if_id_reg dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        bd;
        logic        hold;
        logic        exc;
        logic        eret;
        logic [31:0] epc;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [4:0]  e_exccode;
        logic        e_bd;
        logic        e_valid;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    int n_checks;
    int n_fail;
    int exp_fetched;
    int exp_stalls;

    task automatic check(input string name, input logic [70:0] act, input logic [70:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [70:0] d_out();
        return {bus.D_PC, bus.D_instr, bus.D_exccode, bus.D_bd, bus.D_valid};
    endfunction

    task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic bd,
                         input logic hold, input logic exc, input logic eret,
                         input logic [31:0] epc);
        bus.F_PC    = pc;
        bus.F_instr = instr;
        bus.F_bd    = bd;
        bus.hold    = hold;
        bus.exc     = exc;
        bus.eret    = eret;
        bus.EPC     = epc;
    endtask

    task automatic check_perf(input string name, input int fetched, input int stalls);
`ifdef FETCH_PERF_CNT_EN
        check({name, "_fetched"}, {39'h0, bus.perf_fetched}, {39'h0, fetched[31:0]});
        check({name, "_stalls"},  {39'h0, bus.perf_stalls},  {39'h0, stalls[31:0]});
`else
        check({name, "_fetched"}, {39'h0, bus.perf_fetched}, 71'h0);
        check({name, "_stalls"},  {39'h0, bus.perf_stalls},  71'h0);
        if (fetched < 0 || stalls < 0) $display("negative expected count");
`endif
    endtask

    localparam logic [70:0] RESET_OUT = {32'h0000_3000, 32'h0, 5'd0, 1'b0, 1'b0};

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        exp_fetched = 0;
        exp_stalls  = 0;

        //           pc            instr         bd  hold exc eret epc           e_pc          e_instr       exc  bd  valid
        vecs[0]  = '{32'h0000_3000, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_3000, 32'h1111_1111, 5'd0, 1'b0, 1'b1};
        vecs[1]  = '{32'h0000_3004, 32'h2222_2222, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_3004, 32'h2222_2222, 5'd0, 1'b1, 1'b1};
        vecs[2]  = '{32'h0000_3008, 32'h3333_3333, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_3008, 32'h3333_3333, 5'd0, 1'b0, 1'b1};
        vecs[3]  = '{32'h0000_300c, 32'h4444_4444, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_3008, 32'h3333_3333, 5'd0, 1'b0, 1'b1};
        vecs[4]  = '{32'h0000_3010, 32'h5555_5555, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_3008, 32'h3333_3333, 5'd0, 1'b0, 1'b1};
        vecs[5]  = '{32'h0000_3014, 32'h5656_5656, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_3008, 32'h3333_3333, 5'd0, 1'b0, 1'b1};
        vecs[6]  = '{32'h0000_3002, 32'h6666_6666, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_3002, 32'h0,          5'd4, 1'b0, 1'b1};
        vecs[7]  = '{32'h0000_7000, 32'h7777_7777, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_7000, 32'h0,          5'd4, 1'b0, 1'b1};
        vecs[8]  = '{32'h0000_6ffc, 32'h8888_8888, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_6ffc, 32'h8888_8888, 5'd0, 1'b0, 1'b1};
        vecs[9]  = '{32'h0000_0000, 32'h9999_9999, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0000, 32'h0,          5'd4, 1'b0, 1'b1};
        vecs[10] = '{32'h0000_2ffc, 32'haaaa_aaaa, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_2ffc, 32'h0,          5'd4, 1'b1, 1'b1};
        vecs[11] = '{32'h0000_3020, 32'hbaba_baba, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_4180, 32'h0,          5'd0, 1'b0, 1'b0};
        vecs[12] = '{32'h0000_3024, 32'hbbbb_bbbb, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_3024, 32'hbbbb_bbbb, 5'd0, 1'b1, 1'b1};
        vecs[13] = '{32'h0000_3028, 32'hcdcd_cdcd, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_3010, 32'h0000_4180, 32'h0,  5'd0, 1'b0, 1'b0};
        vecs[14] = '{32'h0000_3028, 32'hcccc_cccc, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_3028, 32'hcccc_cccc, 5'd0, 1'b0, 1'b1};
        vecs[15] = '{32'h0000_302c, 32'hcece_cece, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_3010, 32'h0000_3010, 32'h0,  5'd0, 1'b0, 1'b0};
        vecs[16] = '{32'h0000_3030, 32'hcfcf_cfcf, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_3010, 32'h0,          5'd0, 1'b0, 1'b0};
        vecs[17] = '{32'h0000_3034, 32'hd0d0_d0d0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_3040, 32'h0000_3040, 32'h0,  5'd0, 1'b0, 1'b0};
        vecs[18] = '{32'h0000_3ffc, 32'hdddd_dddd, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_3ffc, 32'hdddd_dddd, 5'd0, 1'b1, 1'b1};
        vecs[19] = '{32'h0000_3000, 32'heeee_eeee, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_4180, 32'h0,          5'd0, 1'b0, 1'b0};

        drive(32'h0000_3000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_state", d_out(), RESET_OUT);
        check_perf("reset", 0, 0);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].pc, vecs[i].instr, vecs[i].bd, vecs[i].hold,
                  vecs[i].exc, vecs[i].eret, vecs[i].epc);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), d_out(),
                  {vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_exccode, vecs[i].e_bd, vecs[i].e_valid});
            $display("vec%0d pc=%h hold=%b exc=%b eret=%b -> D_PC=%h D_instr=%h exc=%0d bd=%b valid=%b",
                     i, vecs[i].pc, vecs[i].hold, vecs[i].exc, vecs[i].eret,
                     bus.D_PC, bus.D_instr, bus.D_exccode, bus.D_bd, bus.D_valid);
            if (!vecs[i].exc && !vecs[i].eret) begin
                if (vecs[i].hold) exp_stalls++;
                else if (vecs[i].e_exccode == 5'd0) exp_fetched++;
            end
        end
        check_perf("table", exp_fetched, exp_stalls);

        // Load a real instruction, then stall and assert reset between edges.
        @(negedge clk);
        drive(32'h0000_3100, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        check("preload", d_out(), {32'h0000_3100, 32'h1234_5678, 5'd0, 1'b1, 1'b1});
        @(negedge clk);
        drive(32'h0000_3104, 32'h8765_4321, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_mid_stall", d_out(), RESET_OUT);
        check_perf("async_reset", 0, 0);
        $display("async reset: D_PC=%h D_valid=%b", bus.D_PC, bus.D_valid);

        // First edge after release still honours hold.
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("hold_after_reset", d_out(), RESET_OUT);
        @(negedge clk);
        drive(32'h0000_3104, 32'h8765_4321, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        check("load_after_reset", d_out(), {32'h0000_3104, 32'h8765_4321, 5'd0, 1'b0, 1'b1});
        check_perf("after_reset", 1, 1);

        // Reset asserted while a flush is pending on the inputs.
        @(negedge clk);
        drive(32'h0000_3108, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        reset = 1'b1;
        #1;
        check("async_reset_mid_flush", d_out(), RESET_OUT);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("exc_after_reset", d_out(), {32'h0000_4180, 32'h0, 5'd0, 1'b0, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id_reg.md
Name: if_id_reg

Overview:
- IF/ID pipeline register directly downstream of the fetch PC stage.
- Captures the fetched PC and instruction into the decode stage each cycle.
- Tags fetch-address exceptions (AdEL) and the branch-delay-slot flag.
- Honours stall (hold) and flushes on exception entry or eret, presenting a clean bubble to decode.

Parameters:
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_END, 32'h0000_6ffc, highest legal fetch address (inclusive).
- EXC_ENTRY, 32'h0000_4180, PC tagged on the bubble inserted by an exception flush.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- F_PC  input  32  PC currently presented by the fetch stage.
- F_instr  input  32  instruction memory read data for F_PC.
- F_bd  input  1  the instruction now in D is a branch/jump, so the F instruction is a delay slot.
- hold  input  1  stall from the hazard unit; freeze the register.
- exc  input  1  exception/interrupt taken this cycle; flush.
- eret  input  1  eret taken this cycle; flush.
- EPC  input  32  return address used to tag the eret bubble.
- D_PC  output  32  decode-stage PC.
- D_instr  output  32  decode-stage instruction (0 = nop when invalid or faulted).
- D_exccode  output  5  fetch exception code (0 = none, 4 = AdEL).
- D_bd  output  1  decode instruction is in a delay slot.
- D_valid  output  1  decode slot holds a real fetched instruction.
- perf_fetched  output  32  valid instructions accepted into D (see Optional Feature).
- perf_stalls  output  32  hold cycles observed (see Optional Feature).

Behaviour:
- Reset (async, immediate):
  - D_PC = IM_BASE.
  - D_instr = 0, D_exccode = 0, D_bd = 0, D_valid = 0.
  - Both perf counters = 0.
- Priority on each rising edge: reset > exc > eret > hold > load.
- exc: D_PC <= EXC_ENTRY; D_instr <= 0; D_exccode <= 0; D_bd <= 0; D_valid <= 0.
- eret (exc low): same as exc, but D_PC <= EPC.
- exc and eret both high: exc wins.
- hold (no flush): all D_* registers keep their values.
- Load (normal cycle):
  - D_PC <= F_PC; D_bd <= F_bd; D_valid <= 1.
  - AdEL is (F_PC[1:0] != 0) or (F_PC < IM_BASE) or (F_PC > IM_END), evaluated combinationally on F_PC.
  - On AdEL: D_instr <= 0, D_exccode <= 4.
  - Otherwise: D_instr <= F_instr, D_exccode <= 0.
- Latency: one cycle from F to D. There is no back-pressure beyond hold.
- Boundaries:
  - F_PC == IM_END: legal. F_PC == IM_END+4: AdEL.
  - F_PC == 0: AdEL.
  - A flush during hold clears the slot. hold does not block the flush.
- Reset asserted mid-stall or mid-flush: outputs go to reset values immediately. The first edge after reset deassertion follows normal priority.
- All comparisons are unsigned 32-bit.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - perf_fetched increments by 1 on each load edge where AdEL is false.
  - perf_stalls increments by 1 on each edge where hold=1 and no flush occurs.
  - Both counters are 32-bit, wrap 32'hffff_ffff -> 0, and are cleared only by reset.
- Undefined: no counter registers; perf_fetched and perf_stalls are tied to 32'h0. The port list is unchanged.

Decomposition:
- Shared package/header holds:
  - ExcCode constants (EXC_NONE=0, EXC_ADEL=4, EXC_ADES=5, EXC_RI=10, EXC_OV=12).
  - Address constants IM_BASE, IM_END, EXC_ENTRY, used also by the PC stage and CP0.
- One natural sub-module: fetch_exc_check. Combinational; takes F_PC and outputs adel.

Test Plan:
- Reset: assert reset asynchronously between edges -> outputs immediately D_PC=32'h3000, D_instr=0, D_valid=0, D_exccode=0.
- Normal flow: F_PC=32'h3000/3004/3008 with distinct instrs -> D_* follow one cycle later, D_valid=1, D_exccode=0.
- Stall: hold=1 for 3 cycles while F_PC changes -> D_PC/D_instr frozen; perf_stalls +3 with FETCH_PERF_CNT_EN, 0 without.
- AdEL:
  - F_PC=32'h3002 -> D_instr=0, D_exccode=4, D_valid=1.
  - F_PC=32'h7000 -> D_exccode=4.
  - F_PC=32'h6ffc -> D_exccode=0.
- Flush:
  - exc=1 together with hold=1 -> D_PC=32'h4180, D_valid=0, D_instr=0.
  - exc=1 together with eret=1, EPC=32'h3010 -> D_PC=32'h4180.
  - eret=1 alone, EPC=32'h3010 -> D_PC=32'h3010, D_valid=0.
- Delay slot: F_bd=1 on a load edge -> D_bd=1. F_bd=1 on an exc edge -> D_bd=0.
